// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// requester identifiers and default geometry of the shared memory.
package dmem_arbiter_pkg;

  // Default number of 32-bit words behind the arbiter and address width
  localparam int DEFAULT_DEPTH = 100;
  localparam int DEFAULT_AW    = 32;

  // Arbiter sequencing: wait, drive the memory for one cycle, answer for one cycle
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Requester identifiers; the core is requester 0, the loader requester 1
  localparam logic REQ_CORE   = 1'b0;
  localparam logic REQ_LOADER = 1'b1;

  // Expands a requester id into a {loader, core} one-hot strobe pair
  function automatic logic [1:0] onehot_id(input logic id);
    return (id == REQ_LOADER) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin priority picker. A lone requester always wins; on a
// tie the requester that was not served last wins. The memory of who was
// served last lives in the caller so this block stays purely combinational.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       grant_valid,
  output logic       grant_id
);

  // Pick the winner from the request pattern and the previous owner
  always_comb begin
    grant_valid = |req;
    grant_id    = REQ_CORE;
    case (req)
      2'b01:   grant_id = REQ_CORE;
      2'b10:   grant_id = REQ_LOADER;
      2'b11:   grant_id = ~last_owner;
      default: grant_id = REQ_CORE;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory (combinational read, synchronous write)
// between the MIPS core load/store path (requester 0) and the test/loader
// port (requester 1). One access is in flight at a time: the winning request
// is captured, the memory is driven for one cycle, and the result is
// presented for one cycle with a valid pulse. Arbitration also happens in the
// response cycle so a continuously requesting port gets one access every two
// cycles. Word addresses at or beyond DEPTH never reach the memory; they
// complete with rdata 0 and an err pulse.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = DEFAULT_AW
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [31:0]   wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [31:0]   rdata0,

  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [31:0]   wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [31:0]   rdata1,

  output logic          err,

  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd,

  output logic          busy
);

  // First illegal word address, widened to the address bus for an unsigned compare
  localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);

  state_t        state;
  logic          owner;
  logic          last_owner;

  // Captured request; addr_q already holds 0 for an out-of-range request so
  // the memory pins can be driven straight from it
  logic          we_q;
  logic          in_range_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;

  logic          grant_valid;
  logic          grant_id;

  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [31:0]   sel_wdata;
  logic          sel_in_range;
  logic [31:0]   access_rdata;

  rr_arb2 u_rr_arb2 (
    .req         ({req1, req0}),
    .last_owner  (last_owner),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Fields of whichever requester the picker chose this cycle
  assign sel_we       = (grant_id == REQ_LOADER) ? we1    : we0;
  assign sel_addr     = (grant_id == REQ_LOADER) ? addr1  : addr0;
  assign sel_wdata    = (grant_id == REQ_LOADER) ? wdata1 : wdata0;
  assign sel_in_range = (sel_addr < DEPTH_A);

  // Writes and rejected addresses answer with zero data
  assign access_rdata = (in_range_q && !we_q) ? mem_rd : 32'h0;

  assign mem_a  = addr_q;
  assign mem_wd = wdata_q;

  // Sequencer: arbitrate in IDLE/RESP, drive memory in ACCESS, answer in RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= REQ_CORE;
      last_owner <= REQ_LOADER;
      we_q       <= 1'b0;
      in_range_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'h0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= 32'h0;
      rdata1     <= 32'h0;
      err        <= 1'b0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE, ST_RESP: begin
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          rdata0  <= 32'h0;
          rdata1  <= 32'h0;
          err     <= 1'b0;
          if (grant_valid) begin
            state        <= ST_ACCESS;
            owner        <= grant_id;
            last_owner   <= grant_id;
            we_q         <= sel_we;
            in_range_q   <= sel_in_range;
            addr_q       <= sel_in_range ? sel_addr : '0;
            wdata_q      <= sel_wdata;
            {gnt1, gnt0} <= onehot_id(grant_id);
            mem_we       <= sel_we && sel_in_range;
            busy         <= 1'b1;
          end else begin
            state  <= ST_IDLE;
            gnt0   <= 1'b0;
            gnt1   <= 1'b0;
            mem_we <= 1'b0;
            busy   <= 1'b0;
          end
        end

        ST_ACCESS: begin
          state   <= ST_RESP;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          mem_we  <= 1'b0;
          rvalid0 <= (owner == REQ_CORE);
          rvalid1 <= (owner == REQ_LOADER);
          rdata0  <= (owner == REQ_CORE)   ? access_rdata : 32'h0;
          rdata1  <= (owner == REQ_LOADER) ? access_rdata : 32'h0;
          err     <= !in_range_q;
          busy    <= 1'b1;
        end

        default: begin
          state   <= ST_IDLE;
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          rvalid0 <= 1'b0;
          rvalid1 <= 1'b0;
          rdata0  <= 32'h0;
          rdata1  <= 32'h0;
          err     <= 1'b0;
          mem_we  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
